// File: rtl/nios_memory_stream_reader.sv
// nios_memory_stream_reader: command-driven sequential RAM reader with a 3-entry backpressure FIFO
module nios_memory_stream_reader #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 5346
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [ADDR_W-1:0] cfg_len,
   output logic              cfg_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic [DATA_W-1:0] st_data,
   output logic              st_valid,
   input  logic              st_ready,
   output logic              st_last
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] addr, rem;
   logic inflight, inflight_last;
   logic [DATA_W:0] fifo [0:2];
   logic [1:0] rd_ptr, wr_ptr, count;
   logic [ADDR_W:0] end_addr;
   logic bad, issue, pop, push, finish;
   assign end_addr = {1'b0, cfg_addr} + {1'b0, cfg_len};
   assign bad = end_addr > (ADDR_W+1)'(DEPTH);
   assign issue = state == RUN && rem != '0 && ({2'b0, inflight} + {1'b0, count}) < 3'd3;
   assign push = inflight;
   assign pop = st_valid && st_ready;
   assign finish = state == DRAIN && !inflight && (count == 2'd0 || (count == 2'd1 && pop));
   assign st_valid = count != 2'd0;
   assign st_data = st_valid ? fifo[rd_ptr][DATA_W-1:0] : '0;
   assign st_last = st_valid && fifo[rd_ptr][DATA_W];
   assign mem_address = addr;
   assign mem_write = 1'b0;
   assign mem_byteenable = 4'hF;
   // state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   // next-state and control outputs
   always_comb begin
      state_nx = state;
      cfg_ready = state == IDLE;
      busy = state != IDLE;
      mem_clken = state != IDLE;
      mem_chipselect = issue;
      case (state)
         IDLE:    if (cfg_start && cfg_len != '0 && !bad) state_nx = RUN;
         RUN:     if (issue && rem == ADDR_W'(1)) state_nx = DRAIN;
         DRAIN:   if (finish) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // command latch, issue counters, read pipeline tracking, FIFO pointers and status flags
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         addr <= '0;
         rem <= '0;
         inflight <= 1'b0;
         inflight_last <= 1'b0;
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         count <= 2'd0;
         done <= 1'b0;
         error <= 1'b0;
      end else begin
         if (state == IDLE && cfg_start) begin
            addr <= cfg_addr;
            rem <= cfg_len;
            error <= cfg_len != '0 && bad;
         end else if (issue) begin
            addr <= addr + ADDR_W'(1);
            rem <= rem - ADDR_W'(1);
         end
         inflight <= issue;
         inflight_last <= issue && rem == ADDR_W'(1);
         done <= (state == IDLE && cfg_start && (cfg_len == '0 || bad)) || finish;
         if (push) wr_ptr <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
         if (pop) rd_ptr <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   // FIFO storage needs no reset; occupancy gates every read of it
   always_ff @(posedge clk)
      if (push) fifo[wr_ptr] <= {inflight_last, mem_readdata};
endmodule

// File: tb/tb_nios_memory_stream_reader.sv
// tb_nios_memory_stream_reader: directed self-checking bench for the memory stream reader
module tb_nios_memory_stream_reader;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int DEPTH = 5346;
   logic clk = 1'b0;
   logic reset_n, cfg_start, cfg_ready, busy, done, error;
   logic [ADDR_W-1:0] cfg_addr, cfg_len, mem_address;
   logic mem_chipselect, mem_write, mem_clken, st_valid, st_ready, st_last;
   logic [3:0] mem_byteenable;
   logic [DATA_W-1:0] mem_readdata, st_data;
   logic [DATA_W-1:0] ram [0:DEPTH-1];
   int checks = 0, errors = 0, cyc = 0, cs_cnt = 0, done_cnt = 0, done_cyc = 0;
   logic [DATA_W-1:0] bd [$];
   logic bl [$];
   int bc [$];
   nios_memory_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
      .cfg_ready(cfg_ready), .busy(busy), .done(done), .error(error), .mem_address(mem_address),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_byteenable(mem_byteenable),
      .mem_clken(mem_clken), .mem_readdata(mem_readdata), .st_data(st_data), .st_valid(st_valid),
      .st_ready(st_ready), .st_last(st_last));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (mem_chipselect && mem_clken) mem_readdata <= ram[mem_address];
   always @(negedge clk) begin
      if (mem_chipselect) cs_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (st_valid && st_ready) begin
         bd.push_back(st_data);
         bl.push_back(st_last);
         bc.push_back(cyc);
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   function automatic logic [DATA_W-1:0] ram_val(input int i);
      return DATA_W'(i) * 32'h01010101;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic start_cmd(input int a, input int l);
      cfg_addr = ADDR_W'(a);
      cfg_len = ADDR_W'(l);
      cfg_start = 1'b1;
      tick(1);
      cfg_start = 1'b0;
   endtask
   task automatic wait_done(input int base, input bit toggle);
      int n = 0;
      while (done_cnt <= base && n < 200) begin
         if (toggle) st_ready = ~st_ready;
         tick(1);
         n++;
      end
      if (done_cnt <= base) check("done timeout", 0, 1);
      st_ready = 1'b1;
   endtask
   task automatic check_beats(input string tag, input int base, input int a, input int n);
      check({tag, " count"}, 32'(bd.size() - base), 32'(n));
      for (int i = 0; i < n && base + i < bd.size(); i++) begin
         check({tag, " data"}, bd[base+i], ram_val(a + i));
         check({tag, " last"}, 32'(bl[base+i]), 32'(i == n - 1));
      end
   endtask
   initial begin
      int b, c, d, n;
      for (int i = 0; i < DEPTH; i++) ram[i] = ram_val(i);
      reset_n = 1'b0;
      cfg_start = 1'b0;
      cfg_addr = '0;
      cfg_len = '0;
      st_ready = 1'b0;
      tick(2);
      check("rst cfg_ready", 32'(cfg_ready), 1);
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst error", 32'(error), 0);
      check("rst chipselect", 32'(mem_chipselect), 0);
      check("rst clken", 32'(mem_clken), 0);
      check("rst address", 32'(mem_address), 0);
      check("rst st_valid", 32'(st_valid), 0);
      check("rst st_last", 32'(st_last), 0);
      check("rst st_data", st_data, 0);
      check("mem_write", 32'(mem_write), 0);
      check("mem_byteenable", 32'(mem_byteenable), 32'hF);
      reset_n = 1'b1;
      tick(1);
      // full-rate burst
      st_ready = 1'b1;
      b = bd.size();
      d = done_cnt;
      start_cmd(0, 8);
      @(negedge clk);
      check("t1 chipselect E0+1", 32'(mem_chipselect), 1);
      check("t1 busy", 32'(busy), 1);
      check("t1 cfg_ready", 32'(cfg_ready), 0);
      check("t1 st_valid E0+1", 32'(st_valid), 0);
      @(negedge clk);
      check("t1 st_valid E1+1", 32'(st_valid), 0);
      @(negedge clk);
      check("t1 st_valid E2+1", 32'(st_valid), 1);
      check("t1 first data", st_data, 0);
      tick(1);
      wait_done(d, 1'b0);
      check_beats("t1", b, 0, 8);
      if (bd.size() >= b + 8) begin
         check("t1 throughput", 32'(bc[b+7] - bc[b]), 7);
         check("t1 done timing", 32'(done_cyc), 32'(bc[b+7] + 1));
      end
      tick(2);
      check("t1 cfg_ready after", 32'(cfg_ready), 1);
      // toggling backpressure
      b = bd.size();
      d = done_cnt;
      c = cs_cnt;
      start_cmd(100, 6);
      wait_done(d, 1'b1);
      check_beats("t2", b, 100, 6);
      check("t2 chipselects", 32'(cs_cnt - c), 6);
      tick(2);
      // long stall
      st_ready = 1'b0;
      b = bd.size();
      d = done_cnt;
      c = cs_cnt;
      start_cmd(10, 5);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (i == 5) check("t3 data early", st_data, ram_val(10));
      end
      check("t3 chipselects stalled", 32'(cs_cnt - c), 3);
      check("t3 st_valid held", 32'(st_valid), 1);
      check("t3 data held", st_data, ram_val(10));
      check("t3 no beats", 32'(bd.size() - b), 0);
      st_ready = 1'b1;
      wait_done(d, 1'b0);
      check_beats("t3", b, 10, 5);
      check("t3 chipselects total", 32'(cs_cnt - c), 5);
      tick(2);
      // range error then the largest legal tail read
      b = bd.size();
      d = done_cnt;
      c = cs_cnt;
      start_cmd(5340, 7);
      @(negedge clk);
      check("t4 error", 32'(error), 1);
      check("t4 done", 32'(done), 1);
      check("t4 busy", 32'(busy), 0);
      tick(4);
      check("t4 error sticky", 32'(error), 1);
      check("t4 chipselects", 32'(cs_cnt - c), 0);
      check("t4 beats", 32'(bd.size() - b), 0);
      check("t4 done count", 32'(done_cnt - d), 1);
      d = done_cnt;
      start_cmd(5340, 6);
      @(negedge clk);
      check("t4b error cleared", 32'(error), 0);
      tick(1);
      wait_done(d, 1'b0);
      check_beats("t4b", b, 5340, 6);
      tick(2);
      // zero length, then a start ignored while running
      b = bd.size();
      d = done_cnt;
      start_cmd(50, 0);
      @(negedge clk);
      check("t5 done", 32'(done), 1);
      check("t5 error", 32'(error), 0);
      check("t5 cfg_ready", 32'(cfg_ready), 1);
      tick(3);
      check("t5 beats", 32'(bd.size() - b), 0);
      check("t5 done count", 32'(done_cnt - d), 1);
      d = done_cnt;
      start_cmd(20, 4);
      start_cmd(200, 2);
      wait_done(d, 1'b0);
      tick(6);
      check_beats("t5b", b, 20, 4);
      check("t5b done count", 32'(done_cnt - d), 1);
      // reset mid-stream
      b = bd.size();
      d = done_cnt;
      start_cmd(30, 8);
      n = 0;
      while (bd.size() < b + 3 && n < 50) begin
         tick(1);
         n++;
      end
      check("t6 three beats", 32'(bd.size() - b), 3);
      #1;
      check("t6 busy before", 32'(busy), 1);
      check("t6 cs before", 32'(mem_chipselect), 1);
      check("t6 valid before", 32'(st_valid), 1);
      reset_n = 1'b0;
      #1;
      check("t6 st_valid async", 32'(st_valid), 0);
      check("t6 busy async", 32'(busy), 0);
      check("t6 chipselect async", 32'(mem_chipselect), 0);
      tick(3);
      reset_n = 1'b1;
      tick(3);
      check("t6 no done", 32'(done_cnt - d), 0);
      b = bd.size();
      start_cmd(0, 2);
      wait_done(d, 1'b0);
      check_beats("t6 after", b, 0, 2);
      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
